// File: rtl/sram_dma_master.sv
// rtl/sram_dma_master.sv - fill/copy/check initiator for the SRAM controller request port
// Optional read-data CRC-32 enabled by defining SRAM_DMA_CRC_EN.
module sram_dma_master #(
  parameter int AW   = 13,
  parameter int DW   = 32,
  parameter int LENW = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [1:0]      mode,
  input  logic [AW-1:0]   src_addr,
  input  logic [AW-1:0]   dst_addr,
  input  logic [LENW-1:0] len,
  input  logic [DW-1:0]   pattern,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [AW-1:0]   err_addr,
  output logic [31:0]     crc,
  output logic            sram_req,
  output logic            sram_we,
  output logic [3:0]      sram_be,
  output logic [AW-1:0]   sram_addr,
  output logic [DW-1:0]   sram_wdata,
  input  logic [DW-1:0]   sram_rdata,
  input  logic            sram_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_COPY_RD, S_COPY_WR, S_CHK, S_CHK_LAST, S_FIN
  } state_t;

  localparam logic [AW-1:0] STRIDE = AW'(DW / 8);

  state_t          state;
  logic [DW-1:0]   pattern_q;
  logic [DW-1:0]   wdata_q;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_addr_q;
  logic [LENW-1:0] cnt;
  logic            rd_pend;
  logic            wr_fresh;
  logic            accepted;
  logic            mismatch;
  logic            launch;

  assign accepted = sram_req & sram_ready;
  assign mismatch = rd_pend & (sram_rdata != pattern_q);
  assign launch   = (state == S_IDLE) & start & ~abort;

  // The copy write data comes straight from rdata on its first cycle, then from the captured copy.
  assign sram_wdata = wr_fresh ? sram_rdata : wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_addr  <= '0;
      sram_req  <= 1'b0;
      sram_we   <= 1'b0;
      sram_be   <= 4'b0000;
      sram_addr <= '0;
      pattern_q <= '0;
      wdata_q   <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      rd_addr_q <= '0;
      cnt       <= '0;
      rd_pend   <= 1'b0;
      wr_fresh  <= 1'b0;
    end else begin
      done      <= 1'b0;
      wr_fresh  <= 1'b0;
      rd_pend   <= (state == S_CHK) & accepted;
      rd_addr_q <= sram_addr;
      case (state)
        S_IDLE: begin
          if (launch) begin
            busy      <= 1'b1;
            err       <= 1'b0;
            err_addr  <= '0;
            pattern_q <= pattern;
            rd_ptr    <= src_addr & ~AW'(3);
            wr_ptr    <= dst_addr & ~AW'(3);
            cnt       <= len;
            if (len == '0) begin
              state <= S_FIN;
            end else if (mode == 2'b01 || mode == 2'b10) begin
              state     <= (mode == 2'b01) ? S_COPY_RD : S_CHK;
              sram_req  <= 1'b1;
              sram_we   <= 1'b0;
              sram_be   <= 4'b0000;
              sram_addr <= src_addr & ~AW'(3);
            end else begin
              state     <= S_FILL;
              sram_req  <= 1'b1;
              sram_we   <= 1'b1;
              sram_be   <= 4'b1111;
              sram_addr <= dst_addr & ~AW'(3);
              wdata_q   <= pattern;
            end
          end
        end
        S_FILL: begin
          if (abort) begin
            sram_req <= 1'b0;
            state    <= S_FIN;
          end else if (sram_ready) begin
            if (cnt == LENW'(1)) begin
              sram_req <= 1'b0;
              state    <= S_FIN;
            end else begin
              cnt       <= cnt - LENW'(1);
              sram_addr <= sram_addr + STRIDE;
            end
          end
        end
        S_COPY_RD: begin
          if (sram_ready) rd_ptr <= rd_ptr + STRIDE;
          if (abort) begin
            sram_req <= 1'b0;
            state    <= S_FIN;
          end else if (sram_ready) begin
            sram_we   <= 1'b1;
            sram_be   <= 4'b1111;
            sram_addr <= wr_ptr;
            wr_fresh  <= 1'b1;
            state     <= S_COPY_WR;
          end
        end
        S_COPY_WR: begin
          if (wr_fresh) wdata_q <= sram_rdata;
          if (abort) begin
            sram_req <= 1'b0;
            state    <= S_FIN;
          end else if (sram_ready) begin
            if (cnt == LENW'(1)) begin
              sram_req <= 1'b0;
              state    <= S_FIN;
            end else begin
              cnt       <= cnt - LENW'(1);
              wr_ptr    <= wr_ptr + STRIDE;
              sram_we   <= 1'b0;
              sram_be   <= 4'b0000;
              sram_addr <= rd_ptr;
              state     <= S_COPY_RD;
            end
          end
        end
        S_CHK: begin
          if (mismatch) begin
            // A read accepted this cycle is simply never compared.
            err      <= 1'b1;
            err_addr <= rd_addr_q;
            sram_req <= 1'b0;
            state    <= S_FIN;
          end else if (abort) begin
            sram_req <= 1'b0;
            state    <= accepted ? S_CHK_LAST : S_FIN;
          end else if (sram_ready) begin
            if (cnt == LENW'(1)) begin
              sram_req <= 1'b0;
              state    <= S_CHK_LAST;
            end else begin
              cnt       <= cnt - LENW'(1);
              sram_addr <= sram_addr + STRIDE;
            end
          end
        end
        S_CHK_LAST: begin
          if (mismatch) begin
            err      <= 1'b1;
            err_addr <= rd_addr_q;
          end
          state <= S_FIN;
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SRAM_DMA_CRC_EN
  logic [31:0] crc_q;
  logic        consume;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [DW-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = DW - 1; i >= 0; i--) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? 32'h04C1_1DB7 : 32'h0);
    end
    return r;
  endfunction

  assign consume = ((state == S_CHK || state == S_CHK_LAST) & rd_pend) |
                   ((state == S_COPY_WR) & wr_fresh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else if (launch) begin
      crc_q <= 32'hFFFF_FFFF;
    end else if (consume) begin
      crc_q <= crc_step(crc_q, sram_rdata);
    end
  end

  assign crc = crc_q;
`else
  assign crc = 32'h0;
`endif

endmodule

// File: tb/tb_sram_dma_master.sv
// tb/tb_sram_dma_master.sv - directed bench for sram_dma_master with a single-port SRAM model
module tb_sram_dma_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [12:0] src_addr = '0;
  logic [12:0] dst_addr = '0;
  logic [11:0] len = '0;
  logic [31:0] pattern = '0;
  logic        busy, done, err;
  logic [12:0] err_addr;
  logic [31:0] crc;
  logic        sram_req, sram_we;
  logic [3:0]  sram_be;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ready = 1'b1;

  sram_dma_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .pattern(pattern),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr), .crc(crc),
    .sram_req(sram_req), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:2047];
  logic        poke_en = 1'b0;
  logic [10:0] poke_idx = '0;
  logic [31:0] poke_data = '0;
  int          cyc = 0;
  logic [12:0] wq[$];
  int          wcyc[$];
  logic [12:0] last_rd = '0;
  int          nrd = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (poke_en) mem[poke_idx] <= poke_data;
    if (sram_req && sram_ready) begin
      if (sram_we) begin
        mem[sram_addr[12:2]] <= sram_wdata;
        wq.push_back(sram_addr);
        wcyc.push_back(cyc);
      end else begin
        sram_rdata <= mem[sram_addr[12:2]];
        last_rd    <= sram_addr;
        nrd        <= nrd + 1;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [12:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = a[12:2]; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Returns at the negedge of cycle 1 (the first cycle after the start edge).
  task automatic launch(input logic [1:0] m, input logic [12:0] s, input logic [12:0] d,
                        input logic [11:0] n, input logic [31:0] p);
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; len = n; pattern = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int from, output int lat);
    lat = from;
    while (!done && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int lat, b, r;
    bit saw_done;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req", 32'(sram_req), 32'd0);
    check("rst_be_addr", {15'd0, sram_be, sram_addr}, 32'd0);
    check("rst_crc", crc, 32'd0);
    rst_n = 1'b1;

    // FILL 4 words
    b = wq.size();
    launch(2'b00, 13'h0, 13'h100, 12'd4, 32'hA5A5_A5A5);
    check("fill_be", 32'(sram_be), 32'hF);
    wait_done("fill", 1, lat);
    check("fill_lat", 32'(lat), 32'd6);
    check("fill_nwr", 32'(wq.size() - b), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill_addr%0d", i), 32'(wq[b+i]), 32'h100 + 32'(4 * i));
      check($sformatf("fill_mem%0d", i), mem[11'h40 + 11'(i)], 32'hA5A5_A5A5);
    end
    check("fill_consec", 32'(wcyc[b+3] - wcyc[b]), 32'd3);
    check("fill_busy", 32'(busy), 32'd0);

    // COPY 3 words
    poke(13'h0, 32'h1111_1111);
    poke(13'h4, 32'h2222_2222);
    poke(13'h8, 32'h3333_3333);
    launch(2'b01, 13'h0, 13'h400, 12'd3, 32'h0);
    check("copy_rd_we_be", {27'd0, sram_we, sram_be}, 32'd0);
    wait_done("copy", 1, lat);
    check("copy_lat", 32'(lat), 32'd8);
    check("copy_mem0", mem[11'h100], 32'h1111_1111);
    check("copy_mem1", mem[11'h101], 32'h2222_2222);
    check("copy_mem2", mem[11'h102], 32'h3333_3333);
    check("copy_err", 32'(err), 32'd0);
`ifndef SRAM_DMA_CRC_EN
    check("copy_crc_off", crc, 32'd0);
`endif

    // len = 0
    b = wq.size();
    launch(2'b00, 13'h0, 13'h700, 12'd0, 32'h1);
    wait_done("len0", 1, lat);
    check("len0_lat", 32'(lat), 32'd2);
    check("len0_nwr", 32'(wq.size() - b), 32'd0);

    // COPY with 2-cycle stall on the second write
    launch(2'b01, 13'h0, 13'h600, 12'd3, 32'h0);
    repeat (3) @(negedge clk);
    check("stall_c4", {sram_req, sram_we, 17'd0, sram_addr}, {2'b11, 17'd0, 13'h604});
    check("stall_c4_wdata", sram_wdata, 32'h2222_2222);
    sram_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("stall_hold%0d", k), {sram_req, sram_we, 17'd0, sram_addr},
            {2'b11, 17'd0, 13'h604});
      check($sformatf("stall_wdata%0d", k), sram_wdata, 32'h2222_2222);
    end
    sram_ready = 1'b1;
    wait_done("stall", 6, lat);
    check("stall_lat", 32'(lat), 32'd10);
    check("stall_mem0", mem[11'h180], 32'h1111_1111);
    check("stall_mem1", mem[11'h181], 32'h2222_2222);
    check("stall_mem2", mem[11'h182], 32'h3333_3333);

    // FILL with wrap, reserved mode behaves as FILL
    b = wq.size();
    launch(2'b11, 13'h0, 13'h1FF8, 12'd3, 32'h0BAD_F00D);
    wait_done("wrap", 1, lat);
    check("wrap_a0", 32'(wq[b]), 32'h1FF8);
    check("wrap_a1", 32'(wq[b+1]), 32'h1FFC);
    check("wrap_a2", 32'(wq[b+2]), 32'h0000);
    check("wrap_mem0", mem[11'h0], 32'h0BAD_F00D);

    // CHECK clean, then with a corrupted word 5
    launch(2'b00, 13'h0, 13'h200, 12'd8, 32'h5A5A_5A5A);
    wait_done("chkfill", 1, lat);
    launch(2'b10, 13'h200, 13'h0, 12'd8, 32'h5A5A_5A5A);
    wait_done("chk_ok", 1, lat);
    check("chk_ok_lat", 32'(lat), 32'd11);
    check("chk_ok_err", 32'(err), 32'd0);
    poke(13'h214, 32'hDEAD_BEEF);
    r = nrd;
    launch(2'b10, 13'h200, 13'h0, 12'd8, 32'h5A5A_5A5A);
    wait_done("chk_bad", 1, lat);
    check("chk_bad_done", 32'(done), 32'd1);
    check("chk_bad_err", 32'(err), 32'd1);
    check("chk_bad_addr", 32'(err_addr), 32'h214);
    check("chk_bad_lastrd", 32'(last_rd), 32'h218);
    check("chk_bad_nrd", 32'(nrd - r), 32'd7);
    launch(2'b00, 13'h0, 13'h700, 12'd0, 32'h0);
    check("err_cleared", 32'(err), 32'd0);
    wait_done("clr", 1, lat);

    // CHECK one zero word: CRC
    poke(13'h300, 32'h0);
    launch(2'b10, 13'h300, 13'h0, 12'd1, 32'h0);
    wait_done("crc", 1, lat);
    check("crc_lat", 32'(lat), 32'd4);
`ifdef SRAM_DMA_CRC_EN
    check("crc_val", crc, 32'hC704_DD7B);
`else
    check("crc_off", crc, 32'd0);
`endif

    // Abort in the third FILL cycle together with a start while busy
    b = wq.size();
    launch(2'b00, 13'h0, 13'h800, 12'd100, 32'h77);
    repeat (2) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort_req", 32'(sram_req), 32'd0);
    wait_done("abort", 4, lat);
    check("abort_lat", 32'(lat), 32'd5);
    check("abort_nwr", 32'(wq.size() - b), 32'd3);
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_one_done", 32'(saw_done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);

    // abort + start together in IDLE
    @(negedge clk);
    mode = 2'b00; dst_addr = 13'h900; len = 12'd4; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (done || busy || sram_req) saw_done = 1'b1;
      @(negedge clk);
    end
    check("idle_abort_start", 32'(saw_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
